// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bundle: pipeline status in, pipeline register/PC control out.
interface hazard_sequencer_if #(
    parameter int REG_ADDR_W = 3
);
    logic                  mem_busy;
    logic                  idex_mem_read;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic [REG_ADDR_W-1:0] id_src_a;
    logic [REG_ADDR_W-1:0] id_src_b;
    logic [REG_ADDR_W-1:0] id_src_c;
    logic [2:0]            id_src_valid;
    logic                  ex_branch_taken;
    logic                  ex_overflow;
    logic                  id_undef;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  idex_write;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic [1:0]            pc_sel;
    logic                  epc_write;
    logic                  cause_write;
    logic                  epc_sel;
    logic [1:0]            cause_code;

    // Pipeline datapath side: reports status, consumes control.
    modport master (
        output mem_busy, idex_mem_read, idex_rd, id_src_a, id_src_b, id_src_c,
               id_src_valid, ex_branch_taken, ex_overflow, id_undef,
        input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush, pc_sel,
               epc_write, cause_write, epc_sel, cause_code
    );

    // Sequencer side.
    modport slave (
        input  mem_busy, idex_mem_read, idex_rd, id_src_a, id_src_b, id_src_c,
               id_src_valid, ex_branch_taken, ex_overflow, id_undef,
        output pc_write, ifid_write, idex_write, ifid_flush, idex_flush, pc_sel,
               epc_write, cause_write, epc_sel, cause_code
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, memory-busy freeze
// and the two-cycle exception entry (EPC/Cause load, then vector fetch).
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   RUN       | normal flow; events resolved by priority this cycle
//   STALL     | extra load-use bubbles while the stall counter runs down
//   EXC_FLUSH | second exception cycle: redirect PC to vector, flush pipe
module hazard_sequencer #(
    parameter int REG_ADDR_W      = 3,
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    hazard_sequencer_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL     = 2'd1,
        EXC_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_CYCLES - 1);

    state_t     state;
    logic [2:0] stall_cnt;

    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  load_use;
    logic                  exc;

    logic       pc_write, ifid_write, idex_write, ifid_flush, idex_flush;
    logic [1:0] pc_sel;
    logic       epc_write, cause_write, epc_sel;
    logic [1:0] cause_code;

    assign ex_rd = hz.idex_rd;

    assign load_use = hz.idex_mem_read &
                      ((hz.id_src_valid[0] && (ex_rd == hz.id_src_a)) ||
                       (hz.id_src_valid[1] && (ex_rd == hz.id_src_b)) ||
                       (hz.id_src_valid[2] && (ex_rd == hz.id_src_c)));

    assign exc = hz.ex_overflow | hz.id_undef;

    // State and stall counter; memory-busy freezes both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            stall_cnt <= 3'd0;
        end else if (!hz.mem_busy) begin
            case (state)
                RUN: begin
                    if (exc) begin
                        state <= EXC_FLUSH;
                    end else if (hz.ex_branch_taken) begin
                        state <= RUN;
                    end else if (load_use && (LOAD_USE_CYCLES > 1)) begin
                        stall_cnt <= STALL_RELOAD;
                        state     <= STALL;
                    end
                end
                STALL: begin
                    stall_cnt <= stall_cnt - 3'd1;
                    if (stall_cnt == 3'd1) begin
                        state <= RUN;
                    end
                end
                EXC_FLUSH: state <= RUN;
                default:   state <= RUN;
            endcase
        end
    end

    // Control outputs decoded from state and current events; all zero in reset or freeze.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pc_sel      = 2'd0;
        epc_write   = 1'b0;
        cause_write = 1'b0;
        epc_sel     = 1'b0;
        cause_code  = 2'd0;
        if (reset && !hz.mem_busy) begin
            case (state)
                RUN: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    idex_write = 1'b1;
                    if (exc) begin
                        pc_write    = 1'b0;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        epc_write   = 1'b1;
                        cause_write = 1'b1;
                        // Overflow belongs to the older instruction in EX.
                        if (hz.ex_overflow) begin
                            cause_code = 2'd2;
                            epc_sel    = 1'b0;
                        end else begin
                            cause_code = 2'd1;
                            epc_sel    = 1'b1;
                        end
                    end else if (hz.ex_branch_taken) begin
                        pc_sel     = 2'd1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                STALL: begin
                    idex_write = 1'b1;
                    idex_flush = 1'b1;
                end
                EXC_FLUSH: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    idex_write = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    pc_sel     = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.idex_write  = idex_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.pc_sel      = pc_sel;
    assign hz.epc_write   = epc_write;
    assign hz.cause_write = cause_write;
    assign hz.epc_sel     = epc_sel;
    assign hz.cause_code  = cause_code;

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control unit for the IF/ID and ID/EX pipeline registers and the PC.
- Generates the write enables and flushes for those registers and the PC redirect select.
- Detects load-use hazards, handles taken-branch flushes and freezes the pipe on memory-busy.
- Sequences the two-cycle exception entry that loads EPC and Cause.

Parameters:
- REG_ADDR_W, 3, register-specifier width.
- LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard (1..7).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_busy  in  1  data memory not ready; freeze whole pipe.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rd  in  REG_ADDR_W  destination of EX instruction.
- id_src_a, id_src_b, id_src_c  in  REG_ADDR_W each  source specifiers of ID instruction.
- id_src_valid  in  3  per-source valid, bit0=a, bit1=b, bit2=c.
- ex_branch_taken  in  1  branch resolved taken in EX.
- ex_overflow  in  1  arithmetic overflow in EX.
- id_undef  in  1  undefined opcode decoded in ID.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID register enable.
- idex_write  out  1  ID/EX register enable (regWrite of ID/EX).
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_flush  out  1  clear ID/EX control fields to bubble.
- pc_sel  out  2  0=PC+2, 1=branch target, 2=exception vector.
- epc_write  out  1  EPC load strobe.
- cause_write  out  1  Cause load strobe.
- epc_sel  out  1  0=EPC from ID/EX PC, 1=EPC from IF/ID PC.
- cause_code  out  2  0=none, 1=undefined instr, 2=overflow.

Behaviour:
- State register: RUN, STALL, EXC_FLUSH. Stall counter is 3 bits.
- While reset=0: state=RUN, counter=0, and every output is forced to 0.
- Outputs are combinational from state and inputs. Default in RUN with no event: pc_write=ifid_write=idex_write=1, flushes=0, pc_sel=0, strobes=0, cause_code=0.
- Event priority in RUN, highest first: mem_busy > exception > branch > load-use.
- mem_busy=1 (any state): pc_write=ifid_write=idex_write=0, flushes=0, strobes=0. State and counter hold.
- Exception, RUN (ex_overflow | id_undef):
  - epc_write=cause_write=1, ifid_flush=idex_flush=1, pc_write=0.
  - ex_overflow wins as the older instruction: cause_code=2, epc_sel=0. Otherwise cause_code=1, epc_sel=1.
  - Next state EXC_FLUSH.
- EXC_FLUSH:
  - ifid_flush=idex_flush=1, pc_sel=2, pc_write=1, strobes=0.
  - ex_*/id_undef/branch inputs ignored.
  - Next state RUN. Exception entry is exactly 2 cycles when not frozen.
- Branch, RUN (ex_branch_taken): pc_sel=1, pc_write=1, ifid_flush=idex_flush=1, no stall, stay RUN. A coincident load-use hazard is discarded (wrong path).
- Load-use hazard: idex_mem_read=1 and idex_rd equals any id_src_x whose valid bit is set.
  - In RUN: pc_write=ifid_write=0, idex_flush=1.
  - If LOAD_USE_CYCLES>1: counter<=LOAD_USE_CYCLES-1, go STALL. Otherwise stay RUN; the next cycle sees the bubble, so the hazard is gone.
- STALL:
  - Same freeze/bubble outputs as the load-use cycle; counter decrements.
  - At counter==1, next state RUN.
  - ex_overflow/branch are ignored, because a bubble is in EX.
- Reset deassertion mid-sequence restarts in RUN. There is no partial exception completion.

Test Plan:
- Reset low for 3 cycles, then high with idle inputs -> all outputs 0 during reset; pc_write=ifid_write=idex_write=1, pc_sel=0 on the first cycle after.
- idex_mem_read=1, idex_rd=3, id_src_b=3, id_src_valid=3'b010, default params -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1, then normal. Same stimulus with id_src_valid=3'b001 -> no stall.
- LOAD_USE_CYCLES=3, hazard asserted -> 3 consecutive stall cycles; state returns to RUN on cycle 4.
- ex_branch_taken=1 together with a load-use match -> one cycle of pc_sel=1, pc_write=1, both flushes=1, no stall.
- ex_overflow=1 and id_undef=1 together -> cycle 1: epc_write=cause_write=1, cause_code=2, epc_sel=0, flushes=1. Cycle 2: pc_sel=2, pc_write=1, flushes=1, strobes=0. Cycle 3: RUN.
- mem_busy=1 for 4 cycles in the middle of a LOAD_USE_CYCLES=3 stall -> all enables 0, counter holds; the stall resumes and completes its remaining cycles after mem_busy drops.
